// File: rtl/uart_mult_frame_ctrl_pkg.sv
// Shared types and helpers for the UART multiplier frame controller.
// Frame states, default sync marker and timeout, byte XOR helper.
package uart_mult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_A    = 3'd1,
        ST_RX_B    = 3'd2,
        ST_RX_CHK  = 3'd3,
        ST_MULT    = 3'd4,
        ST_TX_LOAD = 3'd5,
        ST_TX_WAIT = 3'd6
    } frame_state_t;

    localparam logic [7:0]  SYNC_BYTE_DEF   = 8'hA5;
    localparam logic [27:0] TIMEOUT_DEF     = 28'd1000000;

    // Running byte-wise XOR used for frame and response checksums.
    function automatic logic [7:0] xor8(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_mult_frame_ctrl_if.sv
// Byte/multiplier bus between the frame controller and its environment.
// master = frame controller side, slave = UART wrapper / multiplier side.
interface uart_mult_frame_ctrl_if #(
    parameter int OP_WIDTH = 16
) ();
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  tx_ready;
    logic [7:0]            tx_data;
    logic                  tx_start;
    logic [OP_WIDTH-1:0]   mult_a;
    logic [OP_WIDTH-1:0]   mult_b;
    logic                  mult_start;
    logic                  mult_done;
    logic [2*OP_WIDTH-1:0] mult_result;

    modport master (
        input  rx_data, rx_valid, tx_ready, mult_done, mult_result,
        output tx_data, tx_start, mult_a, mult_b, mult_start
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, mult_done, mult_result,
        input  tx_data, tx_start, mult_a, mult_b, mult_start
    );
endinterface

// File: rtl/uart_mult_frame_ctrl_timeout.sv
// Inter-byte timeout counter: clears on clr or when disabled, pulses expire
// on the cycle the count reaches TIMEOUT_CYCLES-1 without a clear.
module uart_frame_timeout #(
    parameter logic [27:0] TIMEOUT_CYCLES = 28'd1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [27:0] cnt_r;

    // Terminal count detect; a clear in the same cycle wins.
    always_comb begin
        if (en && !clr && (cnt_r == (TIMEOUT_CYCLES - 28'd1))) begin
            expire = 1'b1;
        end else begin
            expire = 1'b0;
        end
    end

    // Idle-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 28'd0;
        end else if (clr || !en || expire) begin
            cnt_r <= 28'd0;
        end else begin
            cnt_r <= cnt_r + 28'd1;
        end
    end

endmodule

// File: rtl/uart_mult_frame_ctrl.sv
// Parses [SYNC, A, B (, CHK)] rx frames, launches the multiplier and streams
// the product back MSB byte first. Optional checksum: UART_FRAME_CHKSUM_EN.
module uart_mult_frame_ctrl
    import uart_mult_pkg::*;
#(
    parameter int          OP_WIDTH       = 16,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter logic [27:0] TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                   clk_int,
    input  logic                   uart_reset,
    uart_mult_frame_ctrl_if.master bus,
    output logic                   frame_error,
    output logic                   busy
);

    localparam int NB = OP_WIDTH / 8;
`ifdef UART_FRAME_CHKSUM_EN
    localparam int TX_NB = 2 * NB + 1;
`else
    localparam int TX_NB = 2 * NB;
`endif
    localparam int TXW   = TX_NB * 8;
    localparam int CNT_W = $clog2(TX_NB + 1);
    localparam logic [CNT_W-1:0] OP_LAST  = CNT_W'(NB - 1);
    localparam logic [CNT_W-1:0] TX_INIT  = CNT_W'(TX_NB);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    frame_state_t          state_r;
    logic [CNT_W-1:0]      byte_cnt_r;
    logic [OP_WIDTH-1:0]   a_sh_r;
    logic [OP_WIDTH-1:0]   b_sh_r;
    logic [OP_WIDTH-1:0]   a_next_s;
    logic [OP_WIDTH-1:0]   b_next_s;
    logic [TXW-1:0]        tx_sh_r;
    logic [7:0]            tx_data_r;
    logic                  tx_start_r;
    logic [OP_WIDTH-1:0]   mult_a_r;
    logic [OP_WIDTH-1:0]   mult_b_r;
    logic                  mult_start_r;
    logic                  frame_error_r;
    logic                  busy_r;
    logic                  tmo_en_s;
    logic                  tmo_expire_s;
`ifdef UART_FRAME_CHKSUM_EN
    logic [7:0]            chk_r;
    logic [7:0]            res_xor_s;
`endif

    assign bus.tx_data    = tx_data_r;
    assign bus.tx_start   = tx_start_r;
    assign bus.mult_a     = mult_a_r;
    assign bus.mult_b     = mult_b_r;
    assign bus.mult_start = mult_start_r;
    assign frame_error    = frame_error_r;
    assign busy           = busy_r;

    // Operand shift-in, MSB byte first.
    always_comb begin
        a_next_s = OP_WIDTH'({a_sh_r, bus.rx_data});
        b_next_s = OP_WIDTH'({b_sh_r, bus.rx_data});
    end

`ifdef UART_FRAME_CHKSUM_EN
    // XOR of all product bytes, appended as the trailing response byte.
    always_comb begin
        res_xor_s = 8'h00;
        for (int i = 0; i < 2 * NB; i++) begin
            res_xor_s = xor8(res_xor_s, bus.mult_result[i*8 +: 8]);
        end
    end
`endif

    // Timeout only runs while a frame is being received.
    always_comb begin
        case (state_r)
            ST_RX_A, ST_RX_B, ST_RX_CHK: tmo_en_s = 1'b1;
            default:                     tmo_en_s = 1'b0;
        endcase
    end

    uart_frame_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk_int),
        .rst_n  (uart_reset),
        .clr    (bus.rx_valid),
        .en     (tmo_en_s),
        .expire (tmo_expire_s)
    );

    // Frame FSM with registered outputs.
    always_ff @(posedge clk_int or negedge uart_reset) begin
        if (!uart_reset) begin
            state_r       <= ST_IDLE;
            byte_cnt_r    <= CNT_ZERO;
            a_sh_r        <= '0;
            b_sh_r        <= '0;
            tx_sh_r       <= '0;
            tx_data_r     <= 8'h00;
            tx_start_r    <= 1'b0;
            mult_a_r      <= '0;
            mult_b_r      <= '0;
            mult_start_r  <= 1'b0;
            frame_error_r <= 1'b0;
            busy_r        <= 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
            chk_r         <= 8'h00;
`endif
        end else begin
            mult_start_r  <= 1'b0;
            frame_error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                        state_r    <= ST_RX_A;
                        busy_r     <= 1'b1;
                        byte_cnt_r <= CNT_ZERO;
`ifdef UART_FRAME_CHKSUM_EN
                        chk_r      <= 8'h00;
`endif
                    end
                end
                ST_RX_A: begin
                    if (bus.rx_valid) begin
                        a_sh_r <= a_next_s;
`ifdef UART_FRAME_CHKSUM_EN
                        chk_r  <= xor8(chk_r, bus.rx_data);
`endif
                        if (byte_cnt_r == OP_LAST) begin
                            byte_cnt_r <= CNT_ZERO;
                            state_r    <= ST_RX_B;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + CNT_ONE;
                        end
                    end else if (tmo_expire_s) begin
                        frame_error_r <= 1'b1;
                        busy_r        <= 1'b0;
                        byte_cnt_r    <= CNT_ZERO;
                        state_r       <= ST_IDLE;
                    end
                end
                ST_RX_B: begin
                    if (bus.rx_valid) begin
                        b_sh_r <= b_next_s;
`ifdef UART_FRAME_CHKSUM_EN
                        chk_r  <= xor8(chk_r, bus.rx_data);
`endif
                        if (byte_cnt_r == OP_LAST) begin
                            byte_cnt_r <= CNT_ZERO;
`ifdef UART_FRAME_CHKSUM_EN
                            state_r    <= ST_RX_CHK;
`else
                            state_r      <= ST_MULT;
                            mult_start_r <= 1'b1;
                            mult_a_r     <= a_sh_r;
                            mult_b_r     <= b_next_s;
`endif
                        end else begin
                            byte_cnt_r <= byte_cnt_r + CNT_ONE;
                        end
                    end else if (tmo_expire_s) begin
                        frame_error_r <= 1'b1;
                        busy_r        <= 1'b0;
                        byte_cnt_r    <= CNT_ZERO;
                        state_r       <= ST_IDLE;
                    end
                end
`ifdef UART_FRAME_CHKSUM_EN
                ST_RX_CHK: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == chk_r) begin
                            state_r      <= ST_MULT;
                            mult_start_r <= 1'b1;
                            mult_a_r     <= a_sh_r;
                            mult_b_r     <= b_sh_r;
                        end else begin
                            frame_error_r <= 1'b1;
                            busy_r        <= 1'b0;
                            state_r       <= ST_IDLE;
                        end
                    end else if (tmo_expire_s) begin
                        frame_error_r <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= ST_IDLE;
                    end
                end
`endif
                ST_MULT: begin
                    if (bus.mult_done) begin
`ifdef UART_FRAME_CHKSUM_EN
                        tx_sh_r <= {bus.mult_result, res_xor_s};
`else
                        tx_sh_r <= bus.mult_result;
`endif
                        byte_cnt_r <= TX_INIT;
                        state_r    <= ST_TX_LOAD;
                    end
                end
                ST_TX_LOAD: begin
                    // Raise once the UART is idle, drop once it has gone busy.
                    if (!tx_start_r) begin
                        if (bus.tx_ready) begin
                            tx_start_r <= 1'b1;
                            tx_data_r  <= tx_sh_r[TXW-1 -: 8];
                        end
                    end else if (!bus.tx_ready) begin
                        tx_start_r <= 1'b0;
                        state_r    <= ST_TX_WAIT;
                    end
                end
                ST_TX_WAIT: begin
                    if (bus.tx_ready) begin
                        if (byte_cnt_r == CNT_ONE) begin
                            byte_cnt_r <= CNT_ZERO;
                            busy_r     <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            byte_cnt_r <= byte_cnt_r - CNT_ONE;
                            tx_sh_r    <= {tx_sh_r[TXW-9:0], 8'h00};
                            state_r    <= ST_TX_LOAD;
                        end
                    end
                end
                default: begin
                    tx_start_r <= 1'b0;
                    busy_r     <= 1'b0;
                    byte_cnt_r <= CNT_ZERO;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
